// File: rtl/serial_subtractor_top.sv
// -----------------------------------------------------------------------------
// serial_subtractor_top
//
// Bit-serial unsigned subtractor. A start request in IDLE latches data_a
// (minuend) and data_b (subtrahend). The block then produces data_a - data_b
// LSB-first, one bit per clock, through a single full-subtractor cell and a
// borrow flip-flop.
//
// Handshake: a request is accepted on a rising clk edge where the block is in
// IDLE and start is 1. busy rises on that edge. WIDTH edges later, result is
// updated, done rises and busy falls on the same edge. Requests seen while
// the block is busy or in DONE are dropped, not queued.
//
// Configuration macro: SERIAL_SUB_STICKY_DONE_EN
//   defined   - done stays high until the next accepted start or until reset
//   undefined - done is a one-cycle pulse while the FSM is in DONE
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   operation request, sampled only in IDLE
//   data_a    in   [WIDTH-1:0] minuend, sampled on an accepted start
//   data_b    in   [WIDTH-1:0] subtrahend, sampled on an accepted start
//   result    out  [WIDTH:0]   {borrow_out, difference}, held until next done
//   done      out  completion strobe (or sticky flag, see above)
//   busy      out  high from the accepted start until done rises
//   dbg_state out  [1:0] current FSM state (0=IDLE, 1=SHIFT, 2=DONE)
// -----------------------------------------------------------------------------
module serial_subtractor_top #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH:0]   result,
    output logic             done,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] shift_a_q;
    logic [WIDTH-1:0] shift_b_q;
    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic [CW-1:0]    bit_cnt_q;
    logic [WIDTH:0]   result_q;
    logic             done_q;
    logic             busy_q;

    // Full-subtractor cell working on the current LSBs.
    logic             a0;
    logic             b0;
    logic             diff_bit_d;
    logic             borrow_d;
    logic [WIDTH-1:0] diff_d;

    always_comb begin
        a0         = shift_a_q[0];
        b0         = shift_b_q[0];
        diff_bit_d = a0 ^ b0 ^ borrow_q;
        borrow_d   = (~a0 & b0) | (~(a0 ^ b0) & borrow_q);
        // New difference bit enters at the MSB; after WIDTH shifts the first
        // bit computed has reached position 0.
        diff_d     = (diff_q >> 1) | ({{(WIDTH-1){1'b0}}, diff_bit_d} << (WIDTH - 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            shift_a_q <= '0;
            shift_b_q <= '0;
            diff_q    <= '0;
            borrow_q  <= 1'b0;
            bit_cnt_q <= '0;
            result_q  <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        shift_a_q <= data_a;
                        shift_b_q <= data_b;
                        diff_q    <= '0;
                        borrow_q  <= 1'b0;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        // Clears a sticky done; a no-op in pulse mode.
                        done_q    <= 1'b0;
                        state_q   <= S_SHIFT;
                    end
                end

                S_SHIFT: begin
                    shift_a_q <= shift_a_q >> 1;
                    shift_b_q <= shift_b_q >> 1;
                    diff_q    <= diff_d;
                    borrow_q  <= borrow_d;
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        // Take the last bit straight from the cell so result
                        // is valid on the same edge done rises.
                        result_q <= {borrow_d, diff_d};
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end
                end

                S_DONE: begin
`ifdef SERIAL_SUB_STICKY_DONE_EN
                    done_q  <= 1'b1;
`else
                    done_q  <= 1'b0;
`endif
                    state_q <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign result    = result_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule
